mc_datapath: RTL and testbench

Multicycle MIPS-subset core: datapath plus internal control FSM, sharing one memory port for instruction fetch and data access.
- Holds non-architectural registers IR, MDR, A, B and ALUOut so that one ALU serves PC increment, branch target and execution.
- The memory port uses a req/ready handshake, so variable-latency memory stalls the core cleanly.
- Sits between the top-level wrapper and the unified instruction/data memory.

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_datapath_ctrl.sv | 180 ++++++++++++++++++
 rtl/mc_datapath.sv | 171 +++++++++++++++++
 tb/tb_mc_datapath.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, functs,
// ALU control encodings, FSM state codes and small datapath helpers.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_HALT   = 4'd12;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic [31:0] signExt(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] aluOp(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
      case (ctl)
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         default: return a + b;
      endcase
   endfunction

   function automatic logic addOverflow(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum);
      return (a[31] == b[31]) && (sum[31] != a[31]);
   endfunction

   function automatic logic subOverflow(input logic [31:0] a, input logic [31:0] b, input logic [31:0] diff);
      return (a[31] != b[31]) && (diff[31] != a[31]);
   endfunction

endpackage

// File: rtl/mc_datapath_ctrl.sv
// Control FSM for mc_datapath: state register, next-state logic and per-state
// control decode. Overflow trapping is present only with MC_OVERFLOW_TRAP_EN.
module mc_ctrl_fsm
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_memDone,
`ifdef MC_OVERFLOW_TRAP_EN
   input  logic       i_overflow,
   output logic       o_trap,
`endif
   output logic [3:0] o_state,
   output logic       o_irWrite,
   output logic       o_pcWrite,
   output logic       o_pcWriteCond,
   output logic [1:0] o_pcSrc,
   output logic       o_iorD,
   output logic       o_memReq,
   output logic       o_memWe,
   output logic       o_regWrite,
   output logic       o_regDst,
   output logic       o_memToReg,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [2:0] o_aluControl,
   output logic       o_aluOutWrite,
   output logic       o_abWrite,
   output logic       o_mdrWrite
);

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [2:0] w_fnCtl;
   logic       w_fnValid;

   assign o_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_fnValid = 1'b1;
      w_fnCtl   = ALU_ADD;
      case (i_funct)
         FN_ADD:  w_fnCtl = ALU_ADD;
         FN_SUB:  w_fnCtl = ALU_SUB;
         FN_AND:  w_fnCtl = ALU_AND;
         FN_OR:   w_fnCtl = ALU_OR;
         FN_SLT:  w_fnCtl = ALU_SLT;
         default: w_fnValid = 1'b0;
      endcase
   end

   // FETCH and the two memory states wait on the handshake; everything else is one cycle
   always_comb begin
      w_next        = r_state;
      o_irWrite     = 1'b0;
      o_pcWrite     = 1'b0;
      o_pcWriteCond = 1'b0;
      o_pcSrc       = PCSRC_ALU;
      o_iorD        = 1'b0;
      o_memReq      = 1'b0;
      o_memWe       = 1'b0;
      o_regWrite    = 1'b0;
      o_regDst      = 1'b0;
      o_memToReg    = 1'b0;
      o_aluSrcA     = 1'b0;
      o_aluSrcB     = SRCB_FOUR;
      o_aluControl  = ALU_ADD;
      o_aluOutWrite = 1'b0;
      o_abWrite     = 1'b0;
      o_mdrWrite    = 1'b0;
`ifdef MC_OVERFLOW_TRAP_EN
      o_trap        = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
            o_memReq = 1'b1;
            if (i_memDone) begin
               o_irWrite = 1'b1;
               o_pcWrite = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            o_abWrite     = 1'b1;
            o_aluSrcB     = SRCB_IMMSH;
            o_aluOutWrite = 1'b1;
            case (i_opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_HALT;
            endcase
         end
         S_MEMADR: begin
            o_aluSrcA     = 1'b1;
            o_aluSrcB     = SRCB_IMM;
            o_aluOutWrite = 1'b1;
            w_next        = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            o_memReq = 1'b1;
            o_iorD   = 1'b1;
            if (i_memDone) begin
               o_mdrWrite = 1'b1;
               w_next     = S_MEMWB;
            end
         end
         S_MEMWB: begin
            o_regWrite = 1'b1;
            o_memToReg = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            o_memReq = 1'b1;
            o_memWe  = 1'b1;
            o_iorD   = 1'b1;
            if (i_memDone) w_next = S_FETCH;
         end
         S_EXEC: begin
            o_aluSrcA     = 1'b1;
            o_aluSrcB     = SRCB_B;
            o_aluControl  = w_fnCtl;
            o_aluOutWrite = w_fnValid;
            w_next        = w_fnValid ? S_ALUWB : S_HALT;
`ifdef MC_OVERFLOW_TRAP_EN
            if (w_fnValid && i_overflow) begin
               o_trap = 1'b1;
               w_next = S_HALT;
            end
`endif
         end
         S_ALUWB: begin
            o_regWrite = 1'b1;
            o_regDst   = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            o_aluSrcA     = 1'b1;
            o_aluSrcB     = SRCB_B;
            o_aluControl  = ALU_SUB;
            o_pcWriteCond = 1'b1;
            o_pcSrc       = PCSRC_ALUOUT;
            w_next        = S_FETCH;
         end
         S_ADDIEX: begin
            o_aluSrcA     = 1'b1;
            o_aluSrcB     = SRCB_IMM;
            o_aluOutWrite = 1'b1;
            w_next        = S_ADDIWB;
`ifdef MC_OVERFLOW_TRAP_EN
            if (i_overflow) begin
               o_trap = 1'b1;
               w_next = S_HALT;
            end
`endif
         end
         S_ADDIWB: begin
            o_regWrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_JUMP: begin
            o_pcWrite = 1'b1;
            o_pcSrc   = PCSRC_JUMP;
            w_next    = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core sharing one req/ready memory port for fetch and data.
// Define MC_OVERFLOW_TRAP_EN to add the exc/epc overflow trap outputs.
module mc_datapath
   import mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc,
   output logic [31:0]       instr,
   output logic [3:0]        state,
   output logic              halted,
   input  logic [4:0]        ra_debug,
   output logic [31:0]       ra_debug_data
`ifdef MC_OVERFLOW_TRAP_EN
   ,
   output logic              exc,
   output logic [31:0]       epc
`endif
);

   logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluOut;
   logic        r_reqEnable;
   logic [31:0] r_rf [32];

   logic        w_irWrite, w_pcWrite, w_pcWriteCond, w_iorD, w_memReq, w_memWe;
   logic        w_regWrite, w_regDst, w_memToReg, w_aluSrcA, w_aluOutWrite, w_abWrite, w_mdrWrite;
   logic [1:0]  w_pcSrc, w_aluSrcB;
   logic [2:0]  w_aluControl;
   logic        w_memDone, w_zero, w_pcEn;
   logic [31:0] w_srcA, w_srcB, w_aluResult, w_immExt, w_pcNext, w_wdata, w_rs, w_rt;
   logic [4:0]  w_waddr;

`ifdef MC_OVERFLOW_TRAP_EN
   logic        w_overflow, w_trap;
   logic        r_exc;
   logic [31:0] r_epc;
`endif

   mc_ctrl_fsm u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .i_opcode      (r_ir[31:26]),
      .i_funct       (r_ir[5:0]),
      .i_memDone     (w_memDone),
`ifdef MC_OVERFLOW_TRAP_EN
      .i_overflow    (w_overflow),
      .o_trap        (w_trap),
`endif
      .o_state       (state),
      .o_irWrite     (w_irWrite),
      .o_pcWrite     (w_pcWrite),
      .o_pcWriteCond (w_pcWriteCond),
      .o_pcSrc       (w_pcSrc),
      .o_iorD        (w_iorD),
      .o_memReq      (w_memReq),
      .o_memWe       (w_memWe),
      .o_regWrite    (w_regWrite),
      .o_regDst      (w_regDst),
      .o_memToReg    (w_memToReg),
      .o_aluSrcA     (w_aluSrcA),
      .o_aluSrcB     (w_aluSrcB),
      .o_aluControl  (w_aluControl),
      .o_aluOutWrite (w_aluOutWrite),
      .o_abWrite     (w_abWrite),
      .o_mdrWrite    (w_mdrWrite)
   );

   // The request is held off while reset is high and for one cycle after it
   assign mem_req   = w_memReq & r_reqEnable & ~rst;
   assign mem_we    = w_memWe & mem_req;
   assign mem_addr  = w_iorD ? r_aluOut[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
   assign mem_wdata = r_b;
   assign w_memDone = mem_req & mem_ready;

   assign pc            = r_pc;
   assign instr         = r_ir;
   assign halted        = (state == S_HALT);
   assign ra_debug_data = (ra_debug == 5'd0) ? 32'd0 : r_rf[ra_debug];

   assign w_rs     = (r_ir[25:21] == 5'd0) ? 32'd0 : r_rf[r_ir[25:21]];
   assign w_rt     = (r_ir[20:16] == 5'd0) ? 32'd0 : r_rf[r_ir[20:16]];
   assign w_immExt = signExt(r_ir[15:0]);
   assign w_waddr  = w_regDst ? r_ir[15:11] : r_ir[20:16];
   assign w_wdata  = w_memToReg ? r_mdr : r_aluOut;
   assign w_srcA   = w_aluSrcA ? r_a : r_pc;

   always_comb begin
      w_srcB = r_b;
      case (w_aluSrcB)
         SRCB_FOUR:  w_srcB = PC_STEP;
         SRCB_IMM:   w_srcB = w_immExt;
         SRCB_IMMSH: w_srcB = {w_immExt[29:0], 2'b00};
         default:    w_srcB = r_b;
      endcase
   end

   assign w_aluResult = aluOp(w_aluControl, w_srcA, w_srcB);
   assign w_zero      = (w_aluResult == 32'd0);
   assign w_pcEn      = w_pcWrite | (w_pcWriteCond & w_zero);

   always_comb begin
      w_pcNext = w_aluResult;
      case (w_pcSrc)
         PCSRC_ALUOUT: w_pcNext = r_aluOut;
         PCSRC_JUMP:   w_pcNext = {r_pc[31:28], r_ir[25:0], 2'b00};
         default:      w_pcNext = w_aluResult;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_ir        <= 32'd0;
         r_mdr       <= 32'd0;
         r_a         <= 32'd0;
         r_b         <= 32'd0;
         r_aluOut    <= 32'd0;
         r_reqEnable <= 1'b0;
      end else begin
         r_reqEnable <= 1'b1;
         if (w_pcEn)        r_pc     <= w_pcNext;
         if (w_irWrite)     r_ir     <= mem_rdata;
         if (w_mdrWrite)    r_mdr    <= mem_rdata;
         if (w_aluOutWrite) r_aluOut <= w_aluResult;
         if (w_abWrite) begin
            r_a <= w_rs;
            r_b <= w_rt;
         end
      end
   end

   // Register file keeps its contents across reset; r0 is never written
   always_ff @(posedge clk) begin
      if (w_regWrite && (w_waddr != 5'd0)) r_rf[w_waddr] <= w_wdata;
   end

`ifdef MC_OVERFLOW_TRAP_EN
   always_comb begin
      w_overflow = 1'b0;
      case (w_aluControl)
         ALU_ADD: w_overflow = addOverflow(w_srcA, w_srcB, w_aluResult);
         ALU_SUB: w_overflow = subOverflow(w_srcA, w_srcB, w_aluResult);
         default: w_overflow = 1'b0;
      endcase
   end

   // pc has already advanced past the trapping instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exc <= 1'b0;
         r_epc <= 32'd0;
      end else if (w_trap) begin
         r_exc <= 1'b1;
         r_epc <= r_pc - PC_STEP;
      end
   end

   assign exc = r_exc;
   assign epc = r_epc;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed programs, a wait-state memory model
// and a monitor that checks every completed memory transaction against a queue.
module tb_mc_datapath;
   import mc_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b1;
   logic [31:0] pc, instr;
   logic [3:0]  state;
   logic        halted;
   logic [4:0]  ra_debug;
   logic [31:0] ra_debug_data;
`ifdef MC_OVERFLOW_TRAP_EN
   logic        exc;
   logic [31:0] epc;
`endif

   logic [31:0] progMem [0:255];
   logic [31:0] wrMem   [0:255];
   logic        wrValid [0:255];
   txn_t        expQ [$];
   int          waitCycles = 0;
   int          waitCnt = 0;
   logic        holdWe;
   logic [31:0] holdAddr, holdData;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   mc_datapath #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .pc            (pc),
      .instr         (instr),
      .state         (state),
      .halted        (halted),
      .ra_debug      (ra_debug),
      .ra_debug_data (ra_debug_data)
`ifdef MC_OVERFLOW_TRAP_EN
      ,
      .exc           (exc),
      .epc           (epc)
`endif
   );

   function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkReg(input string name, input logic [4:0] idx, input logic [31:0] expected);
      ra_debug = idx;
      #1;
      checkOutput(name, ra_debug_data, expected);
   endtask

   task automatic pushTxn(input logic we, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.we   = we;
      t.addr = addr;
      t.data = data;
      expQ.push_back(t);
   endtask

   task automatic clearProg();
      for (int i = 0; i < 256; i++) progMem[i] = 32'd0;
   endtask

   // Hold reset two edges, check the reset state, release and wait for the first fetch
   task automatic applyStimulus();
      int n;
      rst = 1'b1;
      cycles(2);
      checkOutput("rst_pc", pc, 32'h0000_0000);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_state", 32'(state), 32'(S_FETCH));
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      rst = 1'b0;
      n = 0;
      while (!mem_req && n < 50) begin
         cycles(1);
         n++;
      end
      checkOutput("req_start", 32'(mem_req), 32'd1);
   endtask

   // Memory model and scoreboard monitor: decides ready for the coming edge
   always @(negedge clk) begin
      txn_t e;
      if (rst) begin
         for (int i = 0; i < 256; i++) wrValid[i] = 1'b0;
      end
      if (mem_req) begin
         if (waitCnt > 0) begin
            checkOutput("stable_we", 32'(mem_we), 32'(holdWe));
            checkOutput("stable_addr", mem_addr, holdAddr);
            if (holdWe) checkOutput("stable_wdata", mem_wdata, holdData);
         end else begin
            holdWe   = mem_we;
            holdAddr = mem_addr;
            holdData = mem_wdata;
         end
         if (waitCnt >= waitCycles) begin
            mem_ready = 1'b1;
            mem_rdata = wrValid[mem_addr[9:2]] ? wrMem[mem_addr[9:2]] : progMem[mem_addr[9:2]];
            if (mem_we) begin
               wrMem[mem_addr[9:2]]   = mem_wdata;
               wrValid[mem_addr[9:2]] = 1'b1;
            end
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_txn: got we=%0b addr=%h, expected none", mem_we, mem_addr);
            end else begin
               e = expQ.pop_front();
               checkOutput("txn_we", 32'(mem_we), 32'(e.we));
               checkOutput("txn_addr", mem_addr, e.addr);
               if (e.we) checkOutput("txn_wdata", mem_wdata, e.data);
            end
            waitCnt = 0;
         end else begin
            mem_ready = 1'b0;
            waitCnt++;
         end
      end else begin
         mem_ready = 1'b1;
         waitCnt   = 0;
      end
   end

   initial begin
      rst        = 1'b1;
      ra_debug   = 5'd0;
      waitCycles = 0;

      // Arithmetic, store/load with wait states, branch not taken, jump, branch loop
      clearProg();
      progMem[0]  = encI(OP_ADDI, 5'd0, 5'd1, 16'd5);
      progMem[1]  = encI(OP_ADDI, 5'd0, 5'd2, 16'd7);
      progMem[2]  = encR(5'd1, 5'd2, 5'd3, FN_ADD);
      progMem[3]  = encI(OP_SW, 5'd0, 5'd3, 16'd4);
      progMem[4]  = encI(OP_LW, 5'd0, 5'd4, 16'd4);
      progMem[5]  = encI(OP_BEQ, 5'd1, 5'd2, 16'd5);
      progMem[6]  = {6'h02, 26'h0000040};
      progMem[64] = encI(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
      pushTxn(1'b0, 32'h00, 32'd0);
      pushTxn(1'b0, 32'h04, 32'd0);
      pushTxn(1'b0, 32'h08, 32'd0);
      pushTxn(1'b0, 32'h0C, 32'd0);
      pushTxn(1'b1, 32'h04, 32'h0000_000C);
      pushTxn(1'b0, 32'h10, 32'd0);
      pushTxn(1'b0, 32'h04, 32'd0);
      pushTxn(1'b0, 32'h14, 32'd0);
      pushTxn(1'b0, 32'h18, 32'd0);
      pushTxn(1'b0, 32'h100, 32'd0);
      applyStimulus();
      cycles(12);
      checkOutput("add_pc", pc, 32'h0C);
      checkOutput("add_state", 32'(state), 32'(S_FETCH));
      waitCycles = 3;
      checkReg("add_r3", 5'd3, 32'd12);
      cycles(10);
      checkOutput("sw_pc", pc, 32'h10);
      checkOutput("sw_state", 32'(state), 32'(S_FETCH));
      cycles(11);
      checkOutput("lw_pc", pc, 32'h14);
      checkOutput("lw_state", 32'(state), 32'(S_FETCH));
      checkReg("lw_r4", 5'd4, 32'd12);
      cycles(6);
      checkOutput("beq_nt_pc", pc, 32'h18);
      cycles(6);
      checkOutput("j_pc", pc, 32'h100);
      checkOutput("j_fetch_addr", mem_addr, 32'h100);
      waitCycles = 0;
      cycles(1);
      checkOutput("loop_decode_pc", pc, 32'h104);
      checkOutput("loop_decode_state", 32'(state), 32'(S_DECODE));
      cycles(2);
      checkOutput("loop_pc", pc, 32'h100);
      checkOutput("loop_state", 32'(state), 32'(S_FETCH));
      rst = 1'b1;
      checkOutput("phase1_queue", 32'(expQ.size()), 32'd0);
      checkReg("keep_r1", 5'd1, 32'd5);

      // Illegal opcode halts; reset recovers
      clearProg();
      progMem[0] = 32'hFC00_0000;
      pushTxn(1'b0, 32'h00, 32'd0);
      applyStimulus();
      cycles(1);
      checkOutput("ill_decode_halted", 32'(halted), 32'd0);
      checkOutput("ill_decode_state", 32'(state), 32'(S_DECODE));
      cycles(1);
      checkOutput("ill_halted", 32'(halted), 32'd1);
      checkOutput("ill_req", 32'(mem_req), 32'd0);
      cycles(5);
      checkOutput("ill_still_halted", 32'(halted), 32'd1);
      checkOutput("ill_still_req", 32'(mem_req), 32'd0);
      checkOutput("ill_pc", pc, 32'h04);
      rst = 1'b1;
      cycles(2);
      checkOutput("ill_rst_pc", pc, 32'h0);
      checkOutput("ill_rst_halted", 32'(halted), 32'd0);
      checkOutput("phase2_queue", 32'(expQ.size()), 32'd0);

      // R-type ALU operations, signed slt and write to r0
      clearProg();
      progMem[0] = encR(5'd1, 5'd2, 5'd7, FN_SUB);
      progMem[1] = encR(5'd1, 5'd2, 5'd8, FN_AND);
      progMem[2] = encR(5'd1, 5'd2, 5'd9, FN_OR);
      progMem[3] = encR(5'd7, 5'd1, 5'd10, FN_SLT);
      progMem[4] = encR(5'd1, 5'd7, 5'd11, FN_SLT);
      progMem[5] = encR(5'd1, 5'd2, 5'd0, FN_ADD);
      progMem[6] = encI(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
      for (int i = 0; i < 6; i++) pushTxn(1'b0, 32'(i * 4), 32'd0);
      applyStimulus();
      cycles(24);
      checkOutput("alu_pc", pc, 32'h18);
      rst = 1'b1;
      checkOutput("phase3_queue", 32'(expQ.size()), 32'd0);
      checkReg("sub_r7", 5'd7, 32'hFFFF_FFFE);
      checkReg("and_r8", 5'd8, 32'd5);
      checkReg("or_r9", 5'd9, 32'd7);
      checkReg("slt_r10", 5'd10, 32'd1);
      checkReg("slt_r11", 5'd11, 32'd0);
      checkReg("r0_zero", 5'd0, 32'd0);

      // Signed overflow on addi
      clearProg();
      progMem[0]  = encI(OP_ADDI, 5'd0, 5'd5, 16'd3);
      progMem[1]  = encI(OP_LW, 5'd0, 5'd6, 16'h0080);
      progMem[2]  = encI(OP_ADDI, 5'd6, 5'd5, 16'd1);
      progMem[3]  = encI(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
      progMem[32] = 32'h7FFF_FFFF;
      pushTxn(1'b0, 32'h00, 32'd0);
      pushTxn(1'b0, 32'h04, 32'd0);
      pushTxn(1'b0, 32'h80, 32'd0);
      pushTxn(1'b0, 32'h08, 32'd0);
      applyStimulus();
      cycles(13);
      checkOutput("ovf_pc", pc, 32'h0C);
`ifdef MC_OVERFLOW_TRAP_EN
      checkOutput("ovf_halted", 32'(halted), 32'd1);
      checkOutput("ovf_state", 32'(state), 32'(S_HALT));
      checkOutput("ovf_exc", 32'(exc), 32'd1);
      checkOutput("ovf_epc", epc, 32'h08);
`else
      checkOutput("ovf_halted", 32'(halted), 32'd0);
      checkOutput("ovf_state", 32'(state), 32'(S_FETCH));
`endif
      rst = 1'b1;
      checkOutput("phase4_queue", 32'(expQ.size()), 32'd0);
      checkReg("ovf_r6", 5'd6, 32'h7FFF_FFFF);
`ifdef MC_OVERFLOW_TRAP_EN
      checkReg("ovf_r5", 5'd5, 32'd3);
      cycles(2);
      checkOutput("ovf_rst_exc", 32'(exc), 32'd0);
      checkOutput("ovf_rst_epc", epc, 32'd0);
`else
      checkReg("ovf_r5", 5'd5, 32'h8000_0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
